// File: rtl/disp_pkg.sv
// disp_pkg
// Shared definitions for the display source scheduler.
//   DISP_W       - width of one display word (eight hex digits)
//   disp_state_t - scheduler operating mode
package disp_pkg;

  localparam int DISP_W = 32;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    FROZEN = 2'd2
  } disp_state_t;

endpackage

// File: rtl/disp_src_sched_btn_debounce.sv
// btn_debounce
// Two-flop synchronisers for the push button and the mode switches, plus a
// stability counter on the button that emits a one-cycle pulse on a
// debounced press. Release produces no pulse.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   btn_raw     - raw asynchronous push button, active-high
//   sw_raw      - raw asynchronous switches (synchronised only)
//   sw_sync     - synchronised switches
//   step        - one-cycle pulse on a debounced 0->1 of the button
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned N_SW            = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_raw,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_sync,
  output logic            step
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit N_SW carries the button, the low bits carry the switches.
  logic [N_SW:0] sync_meta;
  logic [N_SW:0] sync_q;
  logic          btn_sync;
  logic [CW-1:0] db_cnt;
  logic          db_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {btn_raw, sw_raw};
      sync_q    <= sync_meta;
    end
  end

  assign sw_sync  = sync_q[N_SW-1:0];
  assign btn_sync = sync_q[N_SW];

  // The counter only runs while the input disagrees with the accepted level;
  // any bounce back to the accepted level restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (btn_sync == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        db_lvl <= btn_sync;
        step   <= btn_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_src_sched.sv
// disp_src_sched
// Time-shares the 8-digit display among N_SRC 32-bit requesters. Pages
// advance on a dwell timer (AUTO), on a debounced button (MANUAL), or are
// held (FROZEN). Tracks which hidden sources have fresh data.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   src_data    - source k at [32k+31:32k]
//   src_valid   - per-source fresh-word pulse
//   btn_next    - raw page-step push button
//   sw_auto     - raw switch, 1 = auto-rotate
//   sw_freeze   - raw switch, 1 = freeze (overrides sw_auto)
//   disp_data   - registered word to the display driver
//   page        - index of the shown source
//   page_led    - one-hot copy of page
//   new_flags   - bit k: source k updated and not yet shown
//
// state  | meaning
// MANUAL | page steps only on a debounced button press
// AUTO   | page steps on dwell expiry or button press
// FROZEN | page and display word held; new_flags still collected
module disp_src_sched
  import disp_pkg::*;
#(
  parameter int unsigned N_SRC           = 4,
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PW              = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC*DISP_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic                    btn_next,
  input  logic                    sw_auto,
  input  logic                    sw_freeze,
  output logic [DISP_W-1:0]       disp_data,
  output logic [PW-1:0]           page,
  output logic [N_SRC-1:0]        page_led,
  output logic [N_SRC-1:0]        new_flags
);

  localparam int unsigned DWW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0]  PG_LAST = PW'(N_SRC - 1);

  disp_state_t        state, state_nx;
  logic [1:0]         sw_sync;
  logic               sw_auto_s;
  logic               sw_freeze_s;
  logic               step;
  logic [DWW-1:0]     dw_cnt;
  logic               dw_done;
  logic               advance;
  logic [PW-1:0]      page_nx;
  logic [N_SRC-1:0]   flags_nx;
  logic [DISP_W-1:0]  src_w [N_SRC];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .N_SW            (2)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .sw_raw  ({sw_freeze, sw_auto}),
    .sw_sync (sw_sync),
    .step    (step)
  );

  assign sw_auto_s   = sw_sync[0];
  assign sw_freeze_s = sw_sync[1];

  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      src_w[k] = src_data[k*DISP_W +: DISP_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MANUAL;
    else        state <= state_nx;
  end

  // A coincident step and dwell expiry collapse into one advance.
  always_comb begin
    state_nx = MANUAL;
    dw_done  = 1'b0;
    advance  = 1'b0;
    page_nx  = (page == PG_LAST) ? '0 : page + 1'b1;
    if (sw_freeze_s)    state_nx = FROZEN;
    else if (sw_auto_s) state_nx = AUTO;
    dw_done = (state == AUTO) && (dw_cnt == DW_LAST);
    advance = (state != FROZEN) && (step || dw_done);
  end

  // Held at zero outside AUTO so every entry into AUTO starts a full dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         dw_cnt <= '0;
    else if (state != AUTO || advance)  dw_cnt <= '0;
    else                                dw_cnt <= dw_cnt + 1'b1;
  end

  // On an advance the new page's word is taken live in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page      <= '0;
      page_led  <= N_SRC'(1);
      disp_data <= '0;
    end else if (advance) begin
      page      <= page_nx;
      page_led  <= N_SRC'(1) << page_nx;
      disp_data <= src_w[page_nx];
    end else if (state != FROZEN && src_valid[page]) begin
      disp_data <= src_w[page];
    end
  end

  // Clear is applied after set so an advance onto k wins over src_valid[k]:
  // that word is the one being loaded.
  always_comb begin
    flags_nx = new_flags;
    for (int k = 0; k < N_SRC; k++) begin
      if (src_valid[k] && (PW'(k) != page)) flags_nx[k] = 1'b1;
    end
    if (advance) flags_nx[page_nx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) new_flags <= '0;
    else        new_flags <= flags_nx;
  end

endmodule

// File: tb/tb_disp_src_sched.sv
// Bench for disp_src_sched with N_SRC=4, DWELL_CYCLES=8, DEBOUNCE_CYCLES=4.
// Expected {page, page_led, new_flags, disp_data} tuples are queued when the
// stimulus is driven and popped when the DUT is due to show them.
module tb_disp_src_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         btn_next;
  logic         sw_auto;
  logic         sw_freeze;
  logic [31:0]  disp_data;
  logic [1:0]   page;
  logic [3:0]   page_led;
  logic [3:0]   new_flags;

  disp_src_sched #(
    .N_SRC           (4),
    .DWELL_CYCLES    (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .src_valid (src_valid),
    .btn_next  (btn_next),
    .sw_auto   (sw_auto),
    .sw_freeze (sw_freeze),
    .disp_data (disp_data),
    .page      (page),
    .page_led  (page_led),
    .new_flags (new_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [41:0] v;
  } sb_t;

  sb_t sbq[$];
  sb_t e;
  int  n_vec = 0;
  int  n_err = 0;

  function automatic logic [41:0] expv(int p, logic [3:0] f, logic [31:0] d);
    logic [3:0] led;
    logic [1:0] pg;
    pg  = p[1:0];
    led = 4'b0001 << pg;
    return {pg, led, f, d};
  endfunction

  function automatic logic [41:0] obs();
    return {page, page_led, new_flags, disp_data};
  endfunction

  task automatic sb_push(string nm, int p, logic [3:0] f, logic [31:0] d);
    sb_t t;
    t.name = nm;
    t.v    = expv(p, f, d);
    sbq.push_back(t);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_data = '0; src_valid = '0;
    btn_next = 1'b0; sw_auto = 1'b0; sw_freeze = 1'b0;
    sb_push("reset", 0, 4'b0000, 32'h0);
    tick(2);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    rst_n = 1'b1;
    sb_push("reset_release", 0, 4'b0000, 32'h0);
    tick(2);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
  endtask

  task automatic test_valid_latency();
    src_data[31:0] = 32'h1234_5678;
    sb_push("valid_before_edge", 0, 4'b0000, 32'h0);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    src_valid = 4'b0001;
    sb_push("valid_latency", 0, 4'b0000, 32'h1234_5678);
    tick(1);
    src_valid = '0;
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
  endtask

  task automatic test_auto_rotate();
    for (int k = 0; k < 4; k++) src_data[k*32 +: 32] = 32'hA0 + 32'(k);
    sw_auto = 1'b1;
    // 3 cycles to enter AUTO, then 8 cycles of dwell: first advance at 11.
    sb_push("auto_hold_p0", 0, 4'b0000, 32'h1234_5678);
    tick(10);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        sb_push($sformatf("auto_dwell_p%0d", (i - 1) % 4), (i - 1) % 4, 4'b0000, 32'hA0 + 32'((i - 1) % 4));
        tick(7);
        e = sbq.pop_front(); n_vec++;
        if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
      end
      sb_push($sformatf("auto_adv_p%0d", i % 4), i % 4, 4'b0000, 32'hA0 + 32'(i % 4));
      tick(1);
      e = sbq.pop_front(); n_vec++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    end
  endtask

  task automatic test_manual_debounce();
    sw_auto = 1'b0;
    sb_push("manual_enter", 0, 4'b0000, 32'hA0);
    tick(6);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    btn_next = 1'b1;
    sb_push("glitch_ignored", 0, 4'b0000, 32'hA0);
    tick(2);
    btn_next = 1'b0;
    tick(10);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    btn_next = 1'b1;
    sb_push("press_before_step", 0, 4'b0000, 32'hA0);
    tick(6);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sb_push("press_advance", 1, 4'b0000, 32'hA1);
    tick(1);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sb_push("press_single_advance", 1, 4'b0000, 32'hA1);
    tick(3);
    btn_next = 1'b0;
    tick(10);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
  endtask

  task automatic test_new_flags();
    src_data[64 +: 32] = 32'hB0B0_0002;
    src_valid = 4'b0100;
    sb_push("flag_set_hidden", 1, 4'b0100, 32'hA1);
    tick(1);
    src_valid = '0;
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    // Fresh src_valid[2] lands in the same cycle as the advance onto page 2.
    btn_next = 1'b1;
    tick(6);
    src_data[64 +: 32] = 32'hB2;
    src_valid = 4'b0100;
    sb_push("flag_clear_wins", 2, 4'b0000, 32'hB2);
    tick(1);
    src_valid = '0;
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    tick(3);
    btn_next = 1'b0;
    tick(10);
  endtask

  task automatic test_freeze();
    sw_auto = 1'b1;
    tick(5);
    sw_freeze = 1'b1;
    sb_push("freeze_enter", 2, 4'b0000, 32'hB2);
    tick(6);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    src_data[64 +: 32] = 32'hF2;
    src_valid = 4'b1101;
    sb_push("freeze_hold", 2, 4'b1001, 32'hB2);
    tick(1);
    src_valid = '0;
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    tick(10);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sw_freeze = 1'b0;
    sb_push("unfreeze_dwell", 2, 4'b1001, 32'hB2);
    tick(10);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sb_push("unfreeze_resume", 3, 4'b0001, 32'hA3);
    tick(1);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
  endtask

  task automatic test_reset_mid();
    tick(3);
    #2;
    rst_n = 1'b0;
    sb_push("reset_async_mid", 0, 4'b0000, 32'h0);
    #1;
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sb_push("reset_held", 0, 4'b0000, 32'h0);
    tick(2);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    // sw_auto is still high: AUTO after 3 cycles, first advance at 11.
    sb_push("b2b_hold_p0", 0, 4'b0000, 32'h0);
    tick(10);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sb_push("b2b_adv_p1", 1, 4'b0000, 32'hA1);
    tick(1);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    // Press timed so step coincides with the next dwell expiry.
    tick(1);
    btn_next = 1'b1;
    sb_push("b2b_single_adv", 2, 4'b0000, 32'hF2);
    tick(7);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    tick(3);
    btn_next = 1'b0;
    sb_push("b2b_dwell_restart", 2, 4'b0000, 32'hF2);
    tick(4);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
    sb_push("b2b_next_adv", 3, 4'b0000, 32'hA3);
    tick(1);
    e = sbq.pop_front(); n_vec++;
    if (obs() !== e.v) begin n_err++; $display("FAIL %s: got %h exp %h {page,led,flags,data}", e.name, obs(), e.v); end
  endtask

  initial begin
    test_reset();
    test_valid_latency();
    test_auto_rotate();
    test_manual_debounce();
    test_new_flags();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
